ps2_key_filter: RTL and testbench
=================================

// Module: ps2_key_filter
// PURPOSE
//  Parametrised PS/2 scancode filter: matches a stream of received scancode bytes against NUM_KEYS
//  programmable codes and tracks make/break, including the E0 extended and F0 break prefixes.
//  Per key it keeps a sticky "hit" flag (cleared by the consumer) and a live "held" flag.
//  It sits between the PS/2 receiver byte output and game/UI control logic.
// PARAMETERS
//  NUM_KEYS       4                          number of filtered keys (1..16)
//  KEY_CODES      {8'h1D,8'h1B,8'h1C,8'h23}  packed NUM_KEYS*8 codes; key i = KEY_CODES[8*i+:8]
//  KEY_EXT        4'b0000                    bit i=1: key i matches only after an E0 prefix
//  BREAK_CODE     8'hF0                      break prefix
//  EXT_CODE       8'hE0                      extended prefix
//  TIMEOUT_CYCLES 1_000_000                  prefix timeout; used only with PS2_KEY_TIMEOUT_EN
//  IDX_W          localparam = max(1,$clog2(NUM_KEYS))
// PORTS
//  clock       in   1         system clock; all logic on posedge
//  reset       in   1         synchronous, active-high
//  code_in     in   8         received scancode byte
//  code_valid  in   1         one-cycle strobe, code_in valid
//  clear       in   NUM_KEYS  bit i clears key_hit[i]
//  key_hit     out  NUM_KEYS  sticky: set on make of key i
//  key_held    out  NUM_KEYS  1 between make and break of key i
//  key_event   out  1         one-cycle pulse on any matched make or break
//  key_make    out  1         qualifies key_event: 1=make, 0=break
//  key_index   out  IDX_W     lowest matching key index for key_event
// BEHAVIOUR
//  - Reset is reset, synchronous, active-high; clock is clock. Reset clears all outputs to 0
//    and returns the FSM to IDLE. Reset overrides every other input in the same cycle.
//  - FSM states: IDLE, BRK, EXT, EXT_BRK. Transitions occur only on code_valid:
//    IDLE: F0->BRK, E0->EXT, other->match(make, ext=0), stay IDLE.
//    BRK: F0->BRK, E0->EXT_BRK, other->match(break, ext=0) then IDLE.
//    EXT: F0->EXT_BRK, E0->EXT, other->match(make, ext=1) then IDLE.
//    EXT_BRK: F0/E0->EXT_BRK, other->match(break, ext=1) then IDLE.
//  - Key i matches when code_in==KEY_CODES[i] and KEY_EXT[i]==ext. Unmatched code: FSM still
//    returns to IDLE, no event, no flag change.
//  - Latency: with code_valid in cycle n, key_hit/key_held/key_event/key_make/key_index are
//    registered and visible in cycle n+1. key_event is high for exactly 1 cycle.
//  - Make: key_held[i]<=1 and key_hit[i]<=1 for every matching i. Typematic repeats (make
//    while held) pulse key_event again.
//  - Break: key_held[i]<=0; key_hit untouched. A break without a prior make is legal.
//  - Duplicate codes: all matching bits update; key_index = lowest matching index.
//  - clear[i] together with a make of key i: set wins, key_hit[i]=1.
//  - key_make/key_index hold their last values when key_event=0; both are 0 after reset.
//  - code_valid=0: no state or flag change, except the timeout counter below.
// CONFIGURATION
//  PS2_KEY_TIMEOUT_EN defined: a counter runs while the FSM is in BRK, EXT or EXT_BRK.
//    It restarts on each code_valid. After TIMEOUT_CYCLES cycles without code_valid the FSM
//    returns to IDLE with no event. This recovers from a lost byte.
//  PS2_KEY_TIMEOUT_EN undefined: no counter; prefix states wait indefinitely;
//    TIMEOUT_CYCLES is ignored.
// TESTING (defaults unless stated)
//  - 1C -> next cycle key_hit=0100, key_held=0100, key_event=1, key_make=1, key_index=2.
//  - F0,1C -> key_held[2]=0, key_hit[2] stays 1, key_event pulse with key_make=0, key_index=2.
//  - KEY_EXT=4'b0001: 1D -> no event; E0,1D -> key_held[0]=1; E0,F0,1D -> key_held[0]=0.
//  - clear=0100 in the same cycle as a 1C make -> key_hit[2]=1; clear alone next -> 0.
//  - Reset asserted while in EXT_BRK after E0,F0 -> all outputs 0; then 1D with KEY_EXT=0
//    -> make of key 0.
//  - TIMEOUT_EN, TIMEOUT_CYCLES=8: F0, 10 idle cycles, 1C -> treated as make: key_held[2]=1.

Source files
------------

// File: rtl/ps2_key_filter.sv
// ps2_key_filter
//   Matches a stream of received PS/2 scancode bytes against NUM_KEYS
//   programmable codes. It tracks make/break, including the E0 extended and
//   F0 break prefixes. Each key has a sticky hit flag, which the consumer
//   clears, and a live held flag.
//
//   Optional feature macro: PS2_KEY_TIMEOUT_EN
//     defined   : a pending prefix (BRK/EXT/EXT_BRK) is dropped back to IDLE
//                 after TIMEOUT_CYCLES cycles without code_valid (lost byte).
//     undefined : prefix states wait indefinitely; TIMEOUT_CYCLES unused.
//
//   Ports
//     clock      in  1         system clock, posedge
//     reset      in  1         synchronous, active-high, clears everything
//     code_in    in  8         received scancode byte
//     code_valid in  1         one-cycle strobe qualifying code_in
//     clear      in  NUM_KEYS  bit i clears key_hit[i] (a same-cycle make wins)
//     key_hit    out NUM_KEYS  sticky, set on make of key i
//     key_held   out NUM_KEYS  high between make and break of key i
//     key_event  out 1         one-cycle pulse on any matched make/break
//     key_make   out 1         qualifies key_event: 1=make, 0=break
//     key_index  out IDX_W     lowest matching key index of the last event
//
//   Key i code is KEY_CODES[8*i+:8]; the default puts 1D at key 0, 1B at
//   key 1, 1C at key 2 and 23 at key 3.

module ps2_key_filter #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = 32'h231C1B1D,
  parameter logic [NUM_KEYS-1:0]   KEY_EXT        = '0,
  parameter logic [7:0]            BREAK_CODE     = 8'hF0,
  parameter logic [7:0]            EXT_CODE       = 8'hE0,
  parameter int                    TIMEOUT_CYCLES = 1_000_000,
  localparam int                   IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          code_in,
  input  logic                code_valid,
  input  logic [NUM_KEYS-1:0] clear,
  output logic [NUM_KEYS-1:0] key_hit,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                key_event,
  output logic                key_make,
  output logic [IDX_W-1:0]    key_index
);

  if (NUM_KEYS < 1 || NUM_KEYS > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ps2_key_filter: NUM_KEYS must be 1..16 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] hit_q, hit_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic                event_q, event_d;
  logic                make_q, make_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic                do_match;
  logic                is_brk;
  logic                is_ext;
  logic                timeout;
  logic [NUM_KEYS-1:0] match;
  logic [IDX_W-1:0]    low_idx;

`ifdef PS2_KEY_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts idle cycles spent in a prefix state; expires on the
  // TIMEOUT_CYCLES-th such cycle so the FSM is back in IDLE right after it.
  assign timeout = (state_q != IDLE) && !code_valid &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (code_valid || state_q == IDLE || timeout) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Prefix FSM: only a non-prefix byte triggers a match, tagged with the
  // break/extended context accumulated by the prefixes before it.
  always_comb begin
    state_d  = state_q;
    do_match = 1'b0;
    is_brk   = 1'b0;
    is_ext   = 1'b0;
    if (code_valid) begin
      case (state_q)
        IDLE: begin
          if (code_in == BREAK_CODE) begin
            state_d = BRK;
          end else if (code_in == EXT_CODE) begin
            state_d = EXT;
          end else begin
            do_match = 1'b1;
          end
        end
        BRK: begin
          if (code_in == BREAK_CODE) begin
            state_d = BRK;
          end else if (code_in == EXT_CODE) begin
            state_d = EXT_BRK;
          end else begin
            do_match = 1'b1;
            is_brk   = 1'b1;
            state_d  = IDLE;
          end
        end
        EXT: begin
          if (code_in == BREAK_CODE) begin
            state_d = EXT_BRK;
          end else if (code_in == EXT_CODE) begin
            state_d = EXT;
          end else begin
            do_match = 1'b1;
            is_ext   = 1'b1;
            state_d  = IDLE;
          end
        end
        EXT_BRK: begin
          if (code_in == BREAK_CODE || code_in == EXT_CODE) begin
            state_d = EXT_BRK;
          end else begin
            do_match = 1'b1;
            is_brk   = 1'b1;
            is_ext   = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  // Scanning from the top down leaves the lowest matching index in low_idx.
  always_comb begin
    match   = '0;
    low_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (do_match && code_in == KEY_CODES[8*i +: 8] && KEY_EXT[i] == is_ext) begin
        match[i] = 1'b1;
        low_idx  = IDX_W'(i);
      end
    end
  end

  // Clear is applied before the make set, so a same-cycle make wins.
  always_comb begin
    hit_d   = hit_q & ~clear;
    held_d  = held_q;
    event_d = |match;
    make_d  = make_q;
    idx_d   = idx_q;
    if (is_brk) begin
      held_d = held_q & ~match;
    end else begin
      held_d = held_q | match;
      hit_d  = hit_d | match;
    end
    if (|match) begin
      make_d = ~is_brk;
      idx_d  = low_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      hit_q   <= '0;
      held_q  <= '0;
      event_q <= 1'b0;
      make_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      held_q  <= held_d;
      event_q <= event_d;
      make_q  <= make_d;
      idx_q   <= idx_d;
    end
  end

  assign key_hit   = hit_q;
  assign key_held  = held_q;
  assign key_event = event_q;
  assign key_make  = make_q;
  assign key_index = idx_q;

endmodule

// File: tb/tb_ps2_key_filter.sv
// Bench for ps2_key_filter: two instances (KEY_EXT=0000 and KEY_EXT=0001)
// share one stimulus stream and are compared every cycle against a
// prefix-flag model of the scancode protocol, plus directed literal checks.
module tb_ps2_key_filter;

  localparam int TO = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] code_in = 8'h00;
  logic       code_valid = 1'b0;
  logic [3:0] clear = 4'b0000;

  logic [3:0] hit_w[2];
  logic [3:0] held_w[2];
  logic       ev_w[2];
  logic       mk_w[2];
  logic [1:0] idx_w[2];

  always #5 clock = ~clock;

  ps2_key_filter #(
    .NUM_KEYS(4), .KEY_CODES(32'h231C1B1D), .KEY_EXT(4'b0000), .TIMEOUT_CYCLES(TO)
  ) dut_a (
    .clock(clock), .reset(reset), .code_in(code_in), .code_valid(code_valid),
    .clear(clear), .key_hit(hit_w[0]), .key_held(held_w[0]), .key_event(ev_w[0]),
    .key_make(mk_w[0]), .key_index(idx_w[0])
  );

  ps2_key_filter #(
    .NUM_KEYS(4), .KEY_CODES(32'h231C1B1D), .KEY_EXT(4'b0001), .TIMEOUT_CYCLES(TO)
  ) dut_b (
    .clock(clock), .reset(reset), .code_in(code_in), .code_valid(code_valid),
    .clear(clear), .key_hit(hit_w[1]), .key_held(held_w[1]), .key_event(ev_w[1]),
    .key_make(mk_w[1]), .key_index(idx_w[1])
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] kc[4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
  logic [3:0] m_hit[2];
  logic [3:0] m_held[2];
  logic       m_ev[2];
  logic       m_mk[2];
  logic [1:0] m_idx[2];
  bit         pbrk, pext;
  int         cyc = 0;
  int         last_cyc = 0;

  function automatic bit ext_bit(input int m, input int i);
    return (m == 1) && (i == 0);
  endfunction

  always @(posedge clock) begin : model
    cyc++;
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        m_hit[m] = '0; m_held[m] = '0; m_ev[m] = 1'b0; m_mk[m] = 1'b0; m_idx[m] = '0;
      end
      pbrk = 1'b0; pext = 1'b0; last_cyc = cyc;
    end else begin
      for (int m = 0; m < 2; m++) begin
        m_ev[m]  = 1'b0;
        m_hit[m] = m_hit[m] & ~clear;
      end
      if (code_valid) begin
`ifdef PS2_KEY_TIMEOUT_EN
        if ((pbrk || pext) && (cyc - last_cyc - 1 >= TO)) begin
          pbrk = 1'b0; pext = 1'b0;
        end
`endif
        if (code_in == 8'hF0) begin
          pbrk = 1'b1;
        end else if (code_in == 8'hE0) begin
          pext = 1'b1;
        end else begin
          for (int m = 0; m < 2; m++) begin
            int low;
            low = -1;
            for (int i = 0; i < 4; i++) begin
              if (code_in == kc[i] && ext_bit(m, i) == pext) begin
                if (pbrk) m_held[m][i] = 1'b0;
                else begin
                  m_held[m][i] = 1'b1;
                  m_hit[m][i]  = 1'b1;
                end
                if (low < 0) low = i;
              end
            end
            if (low >= 0) begin
              m_ev[m]  = 1'b1;
              m_mk[m]  = !pbrk;
              m_idx[m] = 2'(low);
            end
          end
          pbrk = 1'b0; pext = 1'b0;
        end
        last_cyc = cyc;
      end
    end
  end

  always @(negedge clock) begin : compare
    if (chk_on) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("model_hit%0d", m),  32'(hit_w[m]),  32'(m_hit[m]));
        chk($sformatf("model_held%0d", m), 32'(held_w[m]), 32'(m_held[m]));
        chk($sformatf("model_ev%0d", m),   32'(ev_w[m]),   32'(m_ev[m]));
        chk($sformatf("model_mk%0d", m),   32'(mk_w[m]),   32'(m_mk[m]));
        chk($sformatf("model_idx%0d", m),  32'(idx_w[m]),  32'(m_idx[m]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b, input logic [3:0] clr);
    code_in = b; code_valid = 1'b1; clear = clr;
    @(negedge clock);
    code_valid = 1'b0; clear = 4'b0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk_on = 1'b1;
    chk("rst_hit",  32'(hit_w[0]),  32'h0);
    chk("rst_held", 32'(held_w[0]), 32'h0);
    chk("rst_ev",   32'(ev_w[0]),   32'h0);
    chk("rst_mk",   32'(mk_w[0]),   32'h0);
    chk("rst_idx",  32'(idx_w[0]),  32'h0);
    reset = 1'b0;

    send(8'h1C, 4'b0000);
    chk("make_hit",  32'(hit_w[0]),  32'h4);
    chk("make_held", 32'(held_w[0]), 32'h4);
    chk("make_ev",   32'(ev_w[0]),   32'h1);
    chk("make_mk",   32'(mk_w[0]),   32'h1);
    chk("make_idx",  32'(idx_w[0]),  32'h2);
    idle(1);
    chk("ev_one_cycle", 32'(ev_w[0]), 32'h0);

    send(8'hF0, 4'b0000);
    send(8'h1C, 4'b0000);
    chk("brk_held", 32'(held_w[0]), 32'h0);
    chk("brk_hit",  32'(hit_w[0]),  32'h4);
    chk("brk_ev",   32'(ev_w[0]),   32'h1);
    chk("brk_mk",   32'(mk_w[0]),   32'h0);
    chk("brk_idx",  32'(idx_w[0]),  32'h2);

    send(8'h1D, 4'b0000);
    chk("plain1D_a_ev",   32'(ev_w[0]),      32'h1);
    chk("plain1D_b_ev",   32'(ev_w[1]),      32'h0);
    chk("plain1D_b_held", 32'(held_w[1][0]), 32'h0);
    send(8'hE0, 4'b0000);
    send(8'h1D, 4'b0000);
    chk("ext1D_b_held", 32'(held_w[1][0]), 32'h1);
    chk("ext1D_b_ev",   32'(ev_w[1]),      32'h1);
    chk("ext1D_a_ev",   32'(ev_w[0]),      32'h0);
    send(8'hE0, 4'b0000);
    send(8'hF0, 4'b0000);
    send(8'h1D, 4'b0000);
    chk("extbrk_b_held", 32'(held_w[1][0]), 32'h0);
    chk("extbrk_b_mk",   32'(mk_w[1]),      32'h0);

    send(8'h1C, 4'b0100);
    chk("clr_set_wins", 32'(hit_w[0][2]), 32'h1);
    clear = 4'b0100;
    @(negedge clock);
    clear = 4'b0000;
    chk("clr_alone", 32'(hit_w[0][2]), 32'h0);

    send(8'hE0, 4'b0000);
    send(8'hF0, 4'b0000);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst2_hit%0d", m),  32'(hit_w[m]),  32'h0);
      chk($sformatf("rst2_held%0d", m), 32'(held_w[m]), 32'h0);
      chk($sformatf("rst2_ev%0d", m),   32'(ev_w[m]),   32'h0);
      chk($sformatf("rst2_mk%0d", m),   32'(mk_w[m]),   32'h0);
      chk($sformatf("rst2_idx%0d", m),  32'(idx_w[m]),  32'h0);
    end
    send(8'h1D, 4'b0000);
    chk("post_rst_ev",   32'(ev_w[0]),   32'h1);
    chk("post_rst_mk",   32'(mk_w[0]),   32'h1);
    chk("post_rst_idx",  32'(idx_w[0]),  32'h0);
    chk("post_rst_held", 32'(held_w[0]), 32'h1);

    send(8'hF0, 4'b0000);
    idle(10);
    send(8'h1C, 4'b0000);
`ifdef PS2_KEY_TIMEOUT_EN
    chk("timeout_held", 32'(held_w[0][2]), 32'h1);
    chk("timeout_mk",   32'(mk_w[0]),      32'h1);
`else
    chk("notimeout_held", 32'(held_w[0][2]), 32'h0);
    chk("notimeout_mk",   32'(mk_w[0]),      32'h0);
`endif

    for (int n = 0; n < 4000; n++) begin
      int sel;
      reset = ($urandom_range(0, 299) == 0);
      clear = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 9) < 5) begin
        sel = $urandom_range(0, 9);
        if (sel < 4)      code_in = kc[sel];
        else if (sel < 6) code_in = 8'hF0;
        else if (sel < 8) code_in = 8'hE0;
        else              code_in = 8'($urandom);
        code_valid = 1'b1;
      end else begin
        code_valid = 1'b0;
      end
      @(negedge clock);
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b0; code_valid = 1'b0; clear = 4'b0000;
        idle($urandom_range(6, 12));
      end
    end

    reset = 1'b0; code_valid = 1'b0; clear = 4'b0000;
    @(negedge clock);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
